// File: rtl/pc_unit.sv
// Program counter and fetch sequencer.
// Handles sequential fetch, stalls, and jump/branch redirects with a flush bubble.
module pc_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jump_en,
  input  logic        br_en,
  input  logic        br_cond,
  input  logic [15:0] jump_offset,
  input  logic        stall,
  input  logic        imem_ready,
  output logic [15:0] pc_out,
  output logic        fetch_valid,
  output logic [15:0] pc_dec,
  output logic        flush
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    FETCH  = 2'd1,
    BUBBLE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_pc;
  logic [15:0] r_pc_dec;
  logic        r_flush;
  logic [15:0] w_pc_nxt;
  logic [15:0] w_dec_nxt;
  logic        w_flush_nxt;
  logic        w_redirect;
  logic [15:0] w_target;
  logic        w_in_fetch;
  logic        w_fire;

  assign w_redirect = jump_en | (br_en & br_cond);
  assign w_target   = r_pc_dec + jump_offset;
  assign w_in_fetch = (r_state == FETCH);
  assign w_fire     = w_in_fetch & imem_ready;

  // Next-state, next-PC and flush decision for the coming edge.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_dec_nxt   = r_pc_dec;
    w_flush_nxt = 1'b0;
    unique case (r_state)
      BOOT: begin
        w_state_nxt = FETCH;
      end
      FETCH: begin
        if (w_redirect) begin
          w_pc_nxt    = w_target;
          w_flush_nxt = 1'b1;
          w_state_nxt = BUBBLE;
        end else if (w_fire && !stall) begin
          w_dec_nxt = r_pc;
          w_pc_nxt  = r_pc + 16'd1;
        end
      end
      BUBBLE: begin
        w_state_nxt = FETCH;
      end
      default: begin
        w_state_nxt = BOOT;
      end
    endcase
  end

  // State, PC pair and registered flush pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= BOOT;
      r_pc     <= RESET_PC;
      r_pc_dec <= RESET_PC;
      r_flush  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_pc_dec <= w_dec_nxt;
      r_flush  <= w_flush_nxt;
    end
  end

  assign pc_out      = r_pc;
  assign pc_dec      = r_pc_dec;
  assign fetch_valid = w_in_fetch;
  assign flush       = r_flush;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit.
// Directed vector table, hand sequences, and a randomized model comparison.
module tb_pc_unit;

  logic        clk;
  logic        rst_n;
  logic        jump_en;
  logic        br_en;
  logic        br_cond;
  logic [15:0] jump_offset;
  logic        stall;
  logic        imem_ready;
  logic [15:0] pc_out;
  logic        fetch_valid;
  logic [15:0] pc_dec;
  logic        flush;

  int total;
  int bad;

  pc_unit #(.RESET_PC(16'h0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .jump_en     (jump_en),
    .br_en       (br_en),
    .br_cond     (br_cond),
    .jump_offset (jump_offset),
    .stall       (stall),
    .imem_ready  (imem_ready),
    .pc_out      (pc_out),
    .fetch_valid (fetch_valid),
    .pc_dec      (pc_dec),
    .flush       (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        j;
    logic        b;
    logic        c;
    logic [15:0] off;
    logic        st;
    logic        rdy;
    logic [15:0] e_pc;
    logic [15:0] e_dec;
    logic        e_fv;
    logic        e_fl;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [15:0] e_pc,
                         input logic [15:0] e_dec, input logic e_fv,
                         input logic e_fl);
    chk({tag, ".pc_out"}, pc_out, e_pc);
    chk({tag, ".pc_dec"}, pc_dec, e_dec);
    chk({tag, ".fetch_valid"}, {15'd0, fetch_valid}, {15'd0, e_fv});
    chk({tag, ".flush"}, {15'd0, flush}, {15'd0, e_fl});
  endtask

  task automatic drive(input logic j, input logic b, input logic c,
                       input logic [15:0] off, input logic st,
                       input logic rdy);
    jump_en     = j;
    br_en       = b;
    br_cond     = c;
    jump_offset = off;
    stall       = st;
    imem_ready  = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic j, input logic b, input logic c,
                     input logic [15:0] off, input logic st,
                     input logic rdy, input logic [15:0] e_pc,
                     input logic [15:0] e_dec, input logic e_fv,
                     input logic e_fl);
    vec_t v;
    v.j = j; v.b = b; v.c = c; v.off = off; v.st = st; v.rdy = rdy;
    v.e_pc = e_pc; v.e_dec = e_dec; v.e_fv = e_fv; v.e_fl = e_fl;
    vt.push_back(v);
  endtask

  // Reference model: fetch address, decode PC, and whether we are
  // just out of reset or sitting in the post-redirect bubble.
  logic [15:0] m_pc;
  logic [15:0] m_dec;
  bit          m_boot;
  bit          m_bub;

  task automatic m_reset();
    m_pc   = 16'h0000;
    m_dec  = 16'h0000;
    m_boot = 1;
    m_bub  = 0;
  endtask

  task automatic m_edge();
    bit take;
    take = jump_en || (br_en && br_cond);
    if (m_boot) begin
      m_boot = 0;
    end else if (m_bub) begin
      m_bub = 0;
    end else if (take) begin
      m_pc  = 16'((32'(m_dec) + 32'(jump_offset)) % 32'h10000);
      m_bub = 1;
    end else if (imem_ready && !stall) begin
      m_dec = m_pc;
      m_pc  = 16'((32'(m_pc) + 1) % 32'h10000);
    end
  endtask

  initial begin
    bit prev_fl;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    drive(0, 0, 0, 16'h0, 0, 1);

    // Sequential fetch, jump with negative offset, bubble ignore,
    // imem wait, stall, stall+jump, wrap branch, not-taken branch.
    add(0,0,0,16'h0000,0,1, 16'h0000,16'h0000,1,0);
    add(0,0,0,16'h0000,0,1, 16'h0001,16'h0000,1,0);
    add(0,0,0,16'h0000,0,1, 16'h0002,16'h0001,1,0);
    add(0,0,0,16'h0000,0,1, 16'h0003,16'h0002,1,0);
    add(0,0,0,16'h0000,0,1, 16'h0004,16'h0003,1,0);
    add(0,0,0,16'h0000,0,1, 16'h0005,16'h0004,1,0);
    add(0,0,0,16'h0000,0,1, 16'h0006,16'h0005,1,0);
    add(1,0,0,16'hFFFD,0,1, 16'h0002,16'h0005,0,1);
    add(1,0,0,16'h0100,0,1, 16'h0002,16'h0005,1,0);
    add(0,0,0,16'h0000,0,0, 16'h0002,16'h0005,1,0);
    add(0,0,0,16'h0000,0,0, 16'h0002,16'h0005,1,0);
    add(0,0,0,16'h0000,1,1, 16'h0002,16'h0005,1,0);
    add(0,0,0,16'h0000,0,1, 16'h0003,16'h0002,1,0);
    add(1,0,0,16'h0010,1,1, 16'h0012,16'h0002,0,1);
    add(0,0,0,16'h0000,0,1, 16'h0012,16'h0002,1,0);
    add(0,0,0,16'h0000,0,1, 16'h0013,16'h0012,1,0);
    add(1,0,0,16'hFFEB,0,0, 16'hFFFD,16'h0012,0,1);
    add(0,0,0,16'h0000,0,1, 16'hFFFD,16'h0012,1,0);
    add(0,0,0,16'h0000,0,1, 16'hFFFE,16'hFFFD,1,0);
    add(0,1,0,16'h0004,0,1, 16'hFFFF,16'hFFFE,1,0);
    add(0,1,1,16'h0004,0,1, 16'h0002,16'hFFFE,0,1);
    add(0,0,0,16'h0000,0,1, 16'h0002,16'hFFFE,1,0);
    add(0,0,1,16'h0055,0,1, 16'h0003,16'h0002,1,0);
    add(0,0,0,16'h0000,0,1, 16'h0004,16'h0003,1,0);

    #12;
    chk_all("rst_hold", 16'h0000, 16'h0000, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_all("boot", 16'h0000, 16'h0000, 0, 0);

    foreach (vt[i]) begin
      drive(vt[i].j, vt[i].b, vt[i].c, vt[i].off, vt[i].st, vt[i].rdy);
      tick();
      chk_all($sformatf("vec%0d", i), vt[i].e_pc, vt[i].e_dec,
              vt[i].e_fv, vt[i].e_fl);
    end

    // Walk up to 0x0010, then hold imem_ready low for three cycles.
    drive(0, 0, 0, 16'h0, 0, 1);
    for (int k = 0; k < 12; k++) tick();
    chk("walk.pc_out", pc_out, 16'h0010);
    drive(0, 0, 0, 16'h0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_all($sformatf("wait%0d", k), 16'h0010, 16'h000F, 1, 0);
    end
    drive(0, 0, 0, 16'h0, 0, 1);
    tick();
    chk_all("wait_done", 16'h0011, 16'h0010, 1, 0);

    // Reset asserted between edges while in the bubble.
    drive(1, 0, 0, 16'h0040, 0, 1);
    tick();
    chk_all("pre_rst_bub", 16'h0050, 16'h0010, 0, 1);
    drive(0, 0, 0, 16'h0, 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("rst_in_bub", 16'h0000, 16'h0000, 0, 0);
    #2;
    rst_n = 1'b1;
    #1;
    chk_all("boot_again", 16'h0000, 16'h0000, 0, 0);
    tick();
    chk_all("first_fetch", 16'h0000, 16'h0000, 1, 0);

    // Randomized run against the model, with occasional resets.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    m_reset();
    prev_fl = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0;
        #1;
        chk_all("rnd_rst", 16'h0000, 16'h0000, 0, 0);
        rst_n = 1'b1;
        m_reset();
        prev_fl = 0;
      end
      drive($urandom_range(0, 9) == 0,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 1) == 1,
            16'($urandom),
            $urandom_range(0, 4) == 0,
            $urandom_range(0, 3) != 0);
      tick();
      m_edge();
      chk_all("rnd", m_pc, m_dec, !m_boot && !m_bub, m_bub);
      chk("rnd.flush_twice", {15'd0, prev_fl && flush}, 16'h0000);
      prev_fl = flush;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
